// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of a 1R/1W SRAM: independent round-robin per port,
// 1-cycle read response routing. Optional write-first bypass: SRAM_ARB_WR_BYPASS_EN.
module sram_port_arbiter #(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_rd_valid,
    input  logic [AW-1:0] m0_rd_addr,
    output logic          m0_rd_ready,
    output logic          m0_rsp_valid,
    output logic [DW-1:0] m0_rsp_data,
    input  logic          m0_wr_valid,
    input  logic [AW-1:0] m0_wr_addr,
    input  logic [DW-1:0] m0_wr_data,
    output logic          m0_wr_ready,
    input  logic          m1_rd_valid,
    input  logic [AW-1:0] m1_rd_addr,
    output logic          m1_rd_ready,
    output logic          m1_rsp_valid,
    output logic [DW-1:0] m1_rsp_data,
    input  logic          m1_wr_valid,
    input  logic [AW-1:0] m1_wr_addr,
    input  logic [DW-1:0] m1_wr_data,
    output logic          m1_wr_ready,
    output logic [AW-1:0] sram_raddr,
    input  logic [DW-1:0] sram_rdata,
    output logic [AW-1:0] sram_waddr,
    output logic [DW-1:0] sram_wdata,
    output logic          sram_wr_enable
);

    logic          rd_pri_r;
    logic          wr_pri_r;
    logic          rsp_pend_r;
    logic          rsp_id_r;
    logic [AW-1:0] raddr_hold_r;
    logic          rd_gnt0_s;
    logic          rd_gnt1_s;
    logic          wr_gnt0_s;
    logic          wr_gnt1_s;
    logic          rd_any_s;
    logic          wr_any_s;
    logic [DW-1:0] rsp_data_s;

    // Grant decode; requests are masked while reset is asserted so no ready leaks out.
    always_comb begin
        rd_gnt0_s = rst_n & m0_rd_valid & (~m1_rd_valid | (rd_pri_r == 1'b0));
        rd_gnt1_s = rst_n & m1_rd_valid & (~m0_rd_valid | (rd_pri_r == 1'b1));
        wr_gnt0_s = rst_n & m0_wr_valid & (~m1_wr_valid | (wr_pri_r == 1'b0));
        wr_gnt1_s = rst_n & m1_wr_valid & (~m0_wr_valid | (wr_pri_r == 1'b1));
        rd_any_s  = rd_gnt0_s | rd_gnt1_s;
        wr_any_s  = wr_gnt0_s | wr_gnt1_s;
    end

    // SRAM port muxing; the read address parks on the last granted one when idle.
    always_comb begin
        if (rd_gnt0_s) begin
            sram_raddr = m0_rd_addr;
        end else if (rd_gnt1_s) begin
            sram_raddr = m1_rd_addr;
        end else begin
            sram_raddr = raddr_hold_r;
        end
        if (wr_gnt1_s) begin
            sram_waddr = m1_wr_addr;
            sram_wdata = m1_wr_data;
        end else begin
            sram_waddr = m0_wr_addr;
            sram_wdata = m0_wr_data;
        end
        sram_wr_enable = wr_any_s;
        m0_rd_ready    = rd_gnt0_s;
        m1_rd_ready    = rd_gnt1_s;
        m0_wr_ready    = wr_gnt0_s;
        m1_wr_ready    = wr_gnt1_s;
    end

    // Priority pointers and response pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pri_r     <= 1'b0;
            wr_pri_r     <= 1'b0;
            rsp_pend_r   <= 1'b0;
            rsp_id_r     <= 1'b0;
            raddr_hold_r <= {AW{1'b0}};
        end else begin
            if (rd_any_s) begin
                rd_pri_r     <= rd_gnt0_s;
                raddr_hold_r <= sram_raddr;
            end else begin
                rd_pri_r     <= rd_pri_r;
                raddr_hold_r <= raddr_hold_r;
            end
            if (wr_any_s) begin
                wr_pri_r <= wr_gnt0_s;
            end else begin
                wr_pri_r <= wr_pri_r;
            end
            rsp_pend_r <= rd_any_s;
            rsp_id_r   <= rd_gnt1_s;
        end
    end

`ifdef SRAM_ARB_WR_BYPASS_EN
    logic          byp_r;
    logic [DW-1:0] byp_data_r;

    // Capture same-cycle write data aimed at the address being read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_r      <= 1'b0;
            byp_data_r <= {DW{1'b0}};
        end else begin
            byp_r      <= rd_any_s & wr_any_s & (sram_raddr == sram_waddr);
            byp_data_r <= sram_wdata;
        end
    end

    // Write-first response data selection.
    always_comb begin
        if (byp_r) begin
            rsp_data_s = byp_data_r;
        end else begin
            rsp_data_s = sram_rdata;
        end
    end
`else
    // Response data comes straight from the SRAM (read-before-write on collision).
    always_comb begin
        rsp_data_s = sram_rdata;
    end
`endif

    assign m0_rsp_valid = rsp_pend_r & ~rsp_id_r;
    assign m1_rsp_valid = rsp_pend_r & rsp_id_r;
    assign m0_rsp_data  = rsp_data_s;
    assign m1_rsp_data  = rsp_data_s;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM emulator and a
// grant/memory reference model.
module tb_sram_port_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_rd_valid, m1_rd_valid, m0_wr_valid, m1_wr_valid;
    logic [AW-1:0] m0_rd_addr, m1_rd_addr, m0_wr_addr, m1_wr_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data;
    logic          m0_rd_ready, m1_rd_ready, m0_wr_ready, m1_wr_ready;
    logic          m0_rsp_valid, m1_rsp_valid;
    logic [DW-1:0] m0_rsp_data, m1_rsp_data;
    logic [AW-1:0] sram_raddr, sram_waddr;
    logic [DW-1:0] sram_rdata, sram_wdata;
    logic          sram_wr_enable;

    always #5 clk = ~clk;

    sram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_rd_valid(m0_rd_valid), .m0_rd_addr(m0_rd_addr), .m0_rd_ready(m0_rd_ready),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
        .m0_wr_valid(m0_wr_valid), .m0_wr_addr(m0_wr_addr), .m0_wr_data(m0_wr_data),
        .m0_wr_ready(m0_wr_ready),
        .m1_rd_valid(m1_rd_valid), .m1_rd_addr(m1_rd_addr), .m1_rd_ready(m1_rd_ready),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
        .m1_wr_valid(m1_wr_valid), .m1_wr_addr(m1_wr_addr), .m1_wr_data(m1_wr_data),
        .m1_wr_ready(m1_wr_ready),
        .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .sram_waddr(sram_waddr),
        .sram_wdata(sram_wdata), .sram_wr_enable(sram_wr_enable)
    );

    // SRAM emulator: registered read, read-before-write, plus a preload path.
    logic [DW-1:0] sram_mem [0:1023];
    logic          pl_en = 1'b0;
    logic [9:0]    pl_addr = 10'd0;
    logic [DW-1:0] pl_data = 16'h0000;
    always @(posedge clk) begin
        sram_rdata <= sram_mem[sram_raddr[9:0]];
        if (sram_wr_enable) sram_mem[sram_waddr[9:0]] <= sram_wdata;
        else if (pl_en) sram_mem[pl_addr] <= pl_data;
    end

    // Reference model state
    int            rd_pri_m, wr_pri_m;
    logic [DW-1:0] mem_m [0:1023];
    logic          exp_v0, exp_v1;
    logic [DW-1:0] exp_d;
    int            checks = 0;
    int            failures = 0;

    function automatic int pick(logic v0, logic v1, int pri);
        if (v0 && v1) return pri;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Advance the model across one rising edge using the currently driven requests.
    task automatic model_edge();
        int rg, wg;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;
        rg = pick(m0_rd_valid, m1_rd_valid, rd_pri_m);
        wg = pick(m0_wr_valid, m1_wr_valid, wr_pri_m);
        ra = (rg == 1) ? m1_rd_addr : m0_rd_addr;
        wa = (wg == 1) ? m1_wr_addr : m0_wr_addr;
        wd = (wg == 1) ? m1_wr_data : m0_wr_data;
        exp_v0 = (rg == 0);
        exp_v1 = (rg == 1);
        if (rg >= 0) begin
            exp_d = mem_m[ra[9:0]];
`ifdef SRAM_ARB_WR_BYPASS_EN
            if (wg >= 0 && wa == ra) exp_d = wd;
`endif
            rd_pri_m = 1 - rg;
        end
        if (wg >= 0) begin
            mem_m[wa[9:0]] = wd;
            wr_pri_m = 1 - wg;
        end
    endtask

    task automatic model_reset();
        rd_pri_m = 0;
        wr_pri_m = 0;
        exp_v0 = 1'b0;
        exp_v1 = 1'b0;
    endtask

    task automatic idle();
        m0_rd_valid = 1'b0; m1_rd_valid = 1'b0;
        m0_wr_valid = 1'b0; m1_wr_valid = 1'b0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [DW-1:0] d);
        idle();
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        mem_m[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
        exp_v0 = 1'b0; exp_v1 = 1'b0;
    endtask

    task automatic test_reset();
        m0_rd_valid = 1'b1; m1_rd_valid = 1'b1; m0_wr_valid = 1'b1; m1_wr_valid = 1'b1;
        m0_rd_addr = 18'h0; m1_rd_addr = 18'h1; m0_wr_addr = 18'h0; m1_wr_addr = 18'h0;
        m0_wr_data = 16'h0; m1_wr_data = 16'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m0_rd_ready, m1_rd_ready, m0_wr_ready, m1_wr_ready} !== 4'b0000) begin
            failures++; $display("FAIL reset_ready got=%b want=0000", {m0_rd_ready, m1_rd_ready, m0_wr_ready, m1_wr_ready});
        end
        checks++;
        if ({m0_rsp_valid, m1_rsp_valid, sram_wr_enable} !== 3'b000) begin
            failures++; $display("FAIL reset_valid got=%b want=000", {m0_rsp_valid, m1_rsp_valid, sram_wr_enable});
        end
        checks++;
        if (sram_raddr !== 18'h0) begin
            failures++; $display("FAIL reset_raddr got=%h want=0", sram_raddr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if ({m0_rd_ready, m1_rd_ready, m0_wr_ready, m1_wr_ready} !== 4'b1010) begin
            failures++; $display("FAIL post_reset_grant got=%b want=1010", {m0_rd_ready, m1_rd_ready, m0_wr_ready, m1_wr_ready});
        end
        model_edge();
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== exp_v0 || m1_rsp_valid !== exp_v1 || (exp_v0 && m0_rsp_data !== exp_d)) begin
            failures++; $display("FAIL post_reset_rsp got=%b%b/%h want=%b%b/%h", m0_rsp_valid, m1_rsp_valid, m0_rsp_data, exp_v0, exp_v1, exp_d);
        end
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_write_then_read();
        idle();
        m0_wr_valid = 1'b1; m0_wr_addr = 18'h00010; m0_wr_data = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (m0_wr_ready !== 1'b1 || sram_wr_enable !== 1'b1 || sram_waddr !== 18'h00010 || sram_wdata !== 16'hBEEF) begin
            failures++; $display("FAIL wr_grant got=%b%b %h=%h want=11 00010=beef", m0_wr_ready, sram_wr_enable, sram_waddr, sram_wdata);
        end
        model_edge();
        @(posedge clk); #1;
        idle();
        m1_rd_valid = 1'b1; m1_rd_addr = 18'h00010;
        @(negedge clk);
        checks++;
        if (m1_rd_ready !== 1'b1 || sram_raddr !== 18'h00010 || sram_wr_enable !== 1'b0) begin
            failures++; $display("FAIL rd_grant got=%b %h we=%b want=1 00010 we=0", m1_rd_ready, sram_raddr, sram_wr_enable);
        end
        model_edge();
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++;
        if (m1_rsp_valid !== 1'b1 || m0_rsp_valid !== 1'b0 || m1_rsp_data !== 16'hBEEF) begin
            failures++; $display("FAIL wr_rd_rsp got=%b%b/%h want=01/beef", m0_rsp_valid, m1_rsp_valid, m1_rsp_data);
        end
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        preload(10'h001, 16'h1111);
        preload(10'h002, 16'h2222);
        m0_rd_valid = 1'b1; m0_rd_addr = 18'h00001;
        m1_rd_valid = 1'b1; m1_rd_addr = 18'h00002;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) idle();
            @(negedge clk);
            if (i < 6) begin
                checks++;
                if (m0_rd_ready !== (i % 2 == 0) || m1_rd_ready !== (i % 2 == 1)) begin
                    failures++; $display("FAIL contention_grant cyc=%0d got=%b%b want=%b%b", i, m0_rd_ready, m1_rd_ready, (i % 2 == 0), (i % 2 == 1));
                end
            end
            if (i > 0) begin
                checks++;
                if (m0_rsp_valid !== ((i - 1) % 2 == 0) || m1_rsp_valid !== ((i - 1) % 2 == 1) ||
                    m0_rsp_data !== (((i - 1) % 2 == 0) ? 16'h1111 : 16'h2222)) begin
                    failures++; $display("FAIL contention_rsp cyc=%0d got=%b%b/%h", i, m0_rsp_valid, m1_rsp_valid, m0_rsp_data);
                end
            end
            model_edge();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_concurrent();
        preload(10'h030, 16'h3333);
        m0_wr_valid = 1'b1; m0_wr_addr = 18'h00020; m0_wr_data = 16'h1234;
        m1_rd_valid = 1'b1; m1_rd_addr = 18'h00030;
        @(negedge clk);
        checks++;
        if (m0_wr_ready !== 1'b1 || m1_rd_ready !== 1'b1 || sram_wr_enable !== 1'b1 || sram_raddr !== 18'h00030) begin
            failures++; $display("FAIL concurrent_grant got=%b%b%b %h want=111 00030", m0_wr_ready, m1_rd_ready, sram_wr_enable, sram_raddr);
        end
        model_edge();
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++;
        if (m1_rsp_valid !== 1'b1 || m0_rsp_valid !== 1'b0 || m1_rsp_data !== 16'h3333) begin
            failures++; $display("FAIL concurrent_rsp got=%b%b/%h want=01/3333", m0_rsp_valid, m1_rsp_valid, m1_rsp_data);
        end
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_collision();
        logic [DW-1:0] want;
`ifdef SRAM_ARB_WR_BYPASS_EN
        want = 16'h5555;
`else
        want = 16'hAAAA;
`endif
        preload(10'h040, 16'hAAAA);
        m0_wr_valid = 1'b1; m0_wr_addr = 18'h00040; m0_wr_data = 16'h5555;
        m1_rd_valid = 1'b1; m1_rd_addr = 18'h00040;
        @(negedge clk);
        model_edge();
        @(posedge clk); #1;
        idle();
        m0_rd_valid = 1'b1; m0_rd_addr = 18'h00040;
        @(negedge clk);
        checks++;
        if (m1_rsp_valid !== 1'b1 || m1_rsp_data !== want) begin
            failures++; $display("FAIL collision_rsp got=%b/%h want=1/%h", m1_rsp_valid, m1_rsp_data, want);
        end
        model_edge();
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_data !== 16'h5555) begin
            failures++; $display("FAIL collision_later got=%b/%h want=1/5555", m0_rsp_valid, m0_rsp_data);
        end
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        idle();
        m1_rd_valid = 1'b1; m1_rd_addr = 18'h00003;
        m0_wr_valid = 1'b1; m0_wr_addr = 18'h00050; m0_wr_data = 16'h0F0F;
        @(negedge clk);
        checks++;
        if (m1_rd_ready !== 1'b1 || m0_wr_ready !== 1'b1) begin
            failures++; $display("FAIL midflight_grant got=%b%b want=11", m1_rd_ready, m0_wr_ready);
        end
        model_edge();
        @(posedge clk); #2;
        rst_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        checks++;
        if (m1_rsp_valid !== 1'b0 || m0_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL midflight_rsp got=%b%b want=00", m0_rsp_valid, m1_rsp_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m0_rd_valid = 1'b1; m1_rd_valid = 1'b1; m0_wr_valid = 1'b1; m1_wr_valid = 1'b1;
        m0_rd_addr = 18'h00004; m1_rd_addr = 18'h00005;
        m0_wr_addr = 18'h00006; m1_wr_addr = 18'h00007;
        m0_wr_data = 16'h6666; m1_wr_data = 16'h7777;
        @(negedge clk);
        checks++;
        if ({m0_rd_ready, m1_rd_ready, m0_wr_ready, m1_wr_ready} !== 4'b1010) begin
            failures++; $display("FAIL midflight_pri got=%b want=1010", {m0_rd_ready, m1_rd_ready, m0_wr_ready, m1_wr_ready});
        end
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int rg, wg;
        for (int i = 0; i < 300; i++) begin
            m0_rd_valid = 1'($urandom_range(0, 1)); m1_rd_valid = 1'($urandom_range(0, 1));
            m0_wr_valid = 1'($urandom_range(0, 1)); m1_wr_valid = 1'($urandom_range(0, 1));
            m0_rd_addr = 18'($urandom_range(0, 7)); m1_rd_addr = 18'($urandom_range(0, 7));
            m0_wr_addr = 18'($urandom_range(0, 7)); m1_wr_addr = 18'($urandom_range(0, 7));
            m0_wr_data = 16'($urandom); m1_wr_data = 16'($urandom);
            @(negedge clk);
            rg = pick(m0_rd_valid, m1_rd_valid, rd_pri_m);
            wg = pick(m0_wr_valid, m1_wr_valid, wr_pri_m);
            checks++;
            if (m0_rd_ready !== (rg == 0) || m1_rd_ready !== (rg == 1) ||
                m0_wr_ready !== (wg == 0) || m1_wr_ready !== (wg == 1) || sram_wr_enable !== (wg >= 0)) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%b%b%b%b%b rg=%0d wg=%0d", i, m0_rd_ready, m1_rd_ready, m0_wr_ready, m1_wr_ready, sram_wr_enable, rg, wg);
            end
            if (wg >= 0) begin
                checks++;
                if (sram_waddr !== ((wg == 1) ? m1_wr_addr : m0_wr_addr) || sram_wdata !== ((wg == 1) ? m1_wr_data : m0_wr_data)) begin
                    failures++; $display("FAIL rand_wport cyc=%0d got=%h/%h", i, sram_waddr, sram_wdata);
                end
            end
            if (rg >= 0) begin
                checks++;
                if (sram_raddr !== ((rg == 1) ? m1_rd_addr : m0_rd_addr)) begin
                    failures++; $display("FAIL rand_raddr cyc=%0d got=%h", i, sram_raddr);
                end
            end
            checks++;
            if (m0_rsp_valid !== exp_v0 || m1_rsp_valid !== exp_v1 ||
                (exp_v0 && m0_rsp_data !== exp_d) || (exp_v1 && m1_rsp_data !== exp_d)) begin
                failures++; $display("FAIL rand_rsp cyc=%0d got=%b%b/%h/%h want=%b%b/%h", i, m0_rsp_valid, m1_rsp_valid, m0_rsp_data, m1_rsp_data, exp_v0, exp_v1, exp_d);
            end
            model_edge();
            @(posedge clk); #1;
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        exp_d = 16'h0000;
        m0_rd_addr = 18'h0; m1_rd_addr = 18'h0; m0_wr_addr = 18'h0; m1_wr_addr = 18'h0;
        m0_wr_data = 16'h0; m1_wr_data = 16'h0;
        idle();
        @(posedge clk); #1;
        for (int a = 0; a < 8; a++) preload(10'(a), 16'($urandom));
        foreach (mem_m[k]) if (k >= 8) mem_m[k] = 16'hxxxx;
        preload(10'h010, 16'h0000);
        preload(10'h020, 16'h0000);
        preload(10'h050, 16'h0000);
        test_reset();
        test_write_then_read();
        test_contention();
        test_concurrent();
        test_collision();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
